// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: default widths, channel indices
// and the standard emulator tick periods for a 100 MHz system clock.
// Optional feature macro used by this block: TICK_GEN_COUNT_EN.
package tick_gen_pkg;

  localparam int NUM_CH_DEF = 2;
  localparam int DIV_W_DEF  = 16;
  localparam int MULT_W_DEF = 5;

  localparam int CH_GB  = 0;
  localparam int CH_NES = 1;

  // 100 MHz / 4.194304 MHz = 23.84 -> 24 ; 100 MHz / 1.789773 MHz = 55.87 -> 56
  localparam int GB_DIV  = 24;
  localparam int NES_DIV = 56;

  // Standard period for a known channel index; 0 leaves the channel disabled.
  function automatic logic [DIV_W_DEF-1:0] std_period(input int ch);
    logic [DIV_W_DEF-1:0] p;
    p = '0;
    if (ch == CH_GB)  p = DIV_W_DEF'(GB_DIV);
    if (ch == CH_NES) p = DIV_W_DEF'(NES_DIV);
    return p;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: accumulates mult_i per cycle and fires when the period
// is reached. Latency: tick registered, one cycle after the threshold crossing.
// Backpressure: none; en_i / mult_i=0 freeze, overruns clamp and set dropped_o.
// Ports: clk, rst (async active-high), en_i, sync_i, div_i (period), mult_i
// (step), clr_drop_i, tick_o, dropped_o, tick_cnt_o (TICK_GEN_COUNT_EN only).
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int MULT_W = MULT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [MULT_W-1:0] mult_i,
  input  logic              clr_drop_i,
  output logic              tick_o,
  output logic              dropped_o
`ifdef TICK_GEN_COUNT_EN
  ,
  output logic [31:0]       tick_cnt_o
`endif
);

  localparam int AW = DIV_W + 1;
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [AW-1:0]    acc_q, acc_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic             tick_q, tick_d;
  logic             dropped_q, dropped_d;
  logic [AW-1:0]    sum;
  logic [AW-1:0]    rem;
  logic [AW-1:0]    div_ext;

`ifdef TICK_GEN_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  always_comb begin
    acc_d     = acc_q;
    div_act_d = div_act_q;
    tick_d    = 1'b0;
    // A new overrun below overrides the clear, so a set in the same cycle wins.
    dropped_d = dropped_q & ~clr_drop_i;
    div_ext   = {1'b0, div_act_q};
    sum       = acc_q + {{(AW-MULT_W){1'b0}}, mult_i};
    rem       = sum - div_ext;

    if (sync_i) begin
      acc_d = '0;
    end else if (en_i) begin
      if (div_act_q == '0) begin
        acc_d = '0;
        if (div_i != '0) div_act_d = div_i;
      end else if (mult_i != '0) begin
        if (sum >= div_ext) begin
          tick_d    = 1'b1;
          div_act_d = div_i;
          if (rem >= div_ext) begin
            // Step larger than the period: keep one tick per cycle, flag the loss.
            acc_d     = {1'b0, div_act_q - DIV_ONE};
            dropped_d = 1'b1;
          end else begin
            // Residue may exceed a shorter new period; next step then ticks at once.
            acc_d = rem;
          end
          if (div_i == '0) acc_d = '0;
        end else begin
          acc_d = sum;
        end
      end
    end
  end

`ifdef TICK_GEN_COUNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (sync_i)      cnt_d = '0;
    else if (tick_d) cnt_d = cnt_q + 32'd1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      div_act_q <= '0;
      tick_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      div_act_q <= div_act_d;
      tick_q    <= tick_d;
      dropped_q <= dropped_d;
    end
  end

`ifdef TICK_GEN_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign tick_cnt_o = cnt_q;
`endif

  assign tick_o    = tick_q;
  assign dropped_o = dropped_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel clock-enable generator feeding emulator core clock enables.
// Latency: each tick is registered, one cycle after its threshold crossing.
// Backpressure: none; en_i holds all channels, overruns set sticky dropped_o.
// Ports: clk, rst (async active-high), en_i, sync_i (phase align), div_i
// (per-channel periods, slice c*DIV_W), mult_i (shared step), clr_drop_i,
// tick_o, dropped_o; tick_cnt_o (NUM_CH*32) only with TICK_GEN_COUNT_EN.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int MULT_W = MULT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    sync_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [MULT_W-1:0]       mult_i,
  input  logic                    clr_drop_i,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       dropped_o
`ifdef TICK_GEN_COUNT_EN
  ,
  output logic [NUM_CH*32-1:0]    tick_cnt_o
`endif
);

  // The step must fit in the accumulator arithmetic without truncation.
  if (MULT_W > DIV_W) begin : g_width_check
    $error("tick_gen: MULT_W must not exceed DIV_W");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tick_gen_ch #(
      .DIV_W  (DIV_W),
      .MULT_W (MULT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i),
      .sync_i     (sync_i),
      .div_i      (div_i[c*DIV_W +: DIV_W]),
      .mult_i     (mult_i),
      .clr_drop_i (clr_drop_i),
      .tick_o     (tick_o[c]),
      .dropped_o  (dropped_o[c])
`ifdef TICK_GEN_COUNT_EN
      ,
      .tick_cnt_o (tick_cnt_o[c*32 +: 32])
`endif
    );
  end

endmodule
